// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM access sequencer.
// Command pin encodings, FSM states and default timings.
package sdram_pkg;

  typedef logic [3:0] cmd_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam cmd_t CMD_NOP  = 4'b0111;
  localparam cmd_t CMD_ACT  = 4'b0011;
  localparam cmd_t CMD_RD   = 4'b0101;
  localparam cmd_t CMD_WR   = 4'b0100;
  localparam cmd_t CMD_PRE  = 4'b0010;
  localparam cmd_t CMD_AREF = 4'b0001;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACTIVATE,
    S_WAIT_RCD,
    S_RW,
    S_WAIT_CL,
    S_PRECHARGE,
    S_WAIT_RP,
    S_REFRESH,
    S_WAIT_RFC
  } state_e;

  localparam int DEF_ROW_W       = 13;
  localparam int DEF_COL_W       = 9;
  localparam int DEF_BANK_W      = 2;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_CAS_LAT     = 2;
  localparam int DEF_T_RP        = 2;
  localparam int DEF_T_RFC       = 7;
  localparam int DEF_RCD_TIMEOUT = 8;

  // Auto-precharge flag bit in the column address phase.
  localparam int A10 = 10;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_delay_counter.sv
// Loadable down-counter shared by the sequencer wait states.
// done_o is high while the count sits at zero.
module sdram_delay_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load takes precedence; otherwise decrement and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_access_sequencer.sv
// Single-access SDRAM command sequencer with refresh servicing.
// Build option: SDRAM_SEQ_AUTO_PRECHARGE_EN selects READA/WRITEA.
module sdram_access_sequencer
  import sdram_pkg::*;
#(
  parameter int ROW_W       = DEF_ROW_W,
  parameter int COL_W       = DEF_COL_W,
  parameter int BANK_W      = DEF_BANK_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CAS_LAT     = DEF_CAS_LAT,
  parameter int T_RP        = DEF_T_RP,
  parameter int T_RFC       = DEF_T_RFC,
  parameter int RCD_TIMEOUT = DEF_RCD_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [BANK_W-1:0] req_bank,
  input  logic [ROW_W-1:0]  req_row,
  input  logic [COL_W-1:0]  req_col,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              ref_req,
  output logic              ref_ack,
  output logic              rcd_start,
  input  logic              rcd_int,
  output logic              rcd_err,
  output logic              sd_cs_n,
  output logic              sd_ras_n,
  output logic              sd_cas_n,
  output logic              sd_we_n,
  output logic [BANK_W-1:0] sd_ba,
  output logic [ROW_W-1:0]  sd_addr,
  output logic [DATA_W-1:0] sd_dq_out,
  output logic              sd_dq_oe,
  input  logic [DATA_W-1:0] sd_dq_in
);

  localparam int CW = $clog2(max2(T_RFC, RCD_TIMEOUT) + 1);
  typedef logic [CW-1:0] cnt_t;

  // Wait-state loads: a state held N clocks loads N-1.
  localparam cnt_t LD_RCD  = cnt_t'(RCD_TIMEOUT - 1);
  localparam cnt_t LD_CL   = cnt_t'(CAS_LAT - 2);
  localparam cnt_t LD_RP   = cnt_t'(T_RP - 2);
  localparam cnt_t LD_RPA  = cnt_t'(T_RP - 1);
  localparam cnt_t LD_RFC  = cnt_t'(T_RFC - 2);

  state_e state_q, state_d;

  logic              wr_q, wr_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  cmd_t              cmd_q, cmd_d;
  logic [BANK_W-1:0] ba_q, ba_d;
  logic [ROW_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] dqo_q, dqo_d;
  logic              oe_q, oe_d;
  logic              rdv_q, rdv_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              start_q, start_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;

  logic accept;
  logic cnt_ld;
  cnt_t cnt_val;
  logic cnt_done;

  sdram_delay_counter #(
    .W (CW)
  ) u_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (cnt_ld),
    .val_i  (cnt_val),
    .done_o (cnt_done)
  );

  // Next state, request latch and registered-output values.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cnt_ld  = 1'b0;
    cnt_val = '0;
    rdv_d   = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (ref_req) begin
          state_d = S_REFRESH;
        end else if (req_valid && ready_q) begin
          accept  = 1'b1;
          state_d = S_ACTIVATE;
        end
      end
      S_ACTIVATE: begin
        state_d = S_WAIT_RCD;
        cnt_ld  = 1'b1;
        cnt_val = LD_RCD;
      end
      S_WAIT_RCD: begin
        if (rcd_int) begin
          state_d = S_RW;
        end else if (cnt_done) begin
          err_d   = 1'b1;
          state_d = S_RW;
        end
      end
      S_RW: begin
        if (wr_q) begin
`ifdef SDRAM_SEQ_AUTO_PRECHARGE_EN
          state_d = S_WAIT_RP;
          cnt_ld  = 1'b1;
          cnt_val = LD_RPA;
`else
          state_d = S_PRECHARGE;
`endif
        end else begin
          state_d = S_WAIT_CL;
          cnt_ld  = 1'b1;
          cnt_val = LD_CL;
        end
      end
      S_WAIT_CL: begin
        if (cnt_done) begin
          rdv_d   = 1'b1;
          rdata_d = sd_dq_in;
`ifdef SDRAM_SEQ_AUTO_PRECHARGE_EN
          state_d = S_WAIT_RP;
          cnt_ld  = 1'b1;
          cnt_val = LD_RPA;
`else
          state_d = S_PRECHARGE;
`endif
        end
      end
      S_PRECHARGE: begin
        if (T_RP > 1) begin
          state_d = S_WAIT_RP;
          cnt_ld  = 1'b1;
          cnt_val = LD_RP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_RP: begin
        if (cnt_done) begin
          state_d = S_IDLE;
        end
      end
      S_REFRESH: begin
        if (T_RFC > 1) begin
          state_d = S_WAIT_RFC;
          cnt_ld  = 1'b1;
          cnt_val = LD_RFC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_RFC: begin
        if (cnt_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_d    = accept ? req_write : wr_q;
    bank_d  = accept ? req_bank  : bank_q;
    row_d   = accept ? req_row   : row_q;
    col_d   = accept ? req_col   : col_q;
    wdata_d = accept ? req_wdata : wdata_q;

    cmd_d   = CMD_NOP;
    ba_d    = '0;
    addr_d  = '0;
    dqo_d   = '0;
    oe_d    = 1'b0;
    ack_d   = 1'b0;
    start_d = 1'b0;
    ready_d = 1'b0;

    unique case (state_d)
      S_IDLE: begin
        ready_d = ~ref_req;
      end
      S_ACTIVATE: begin
        cmd_d  = CMD_ACT;
        ba_d   = bank_d;
        addr_d = row_d;
      end
      S_WAIT_RCD: begin
        start_d = 1'b1;
      end
      S_RW: begin
        cmd_d  = wr_q ? CMD_WR : CMD_RD;
        ba_d   = bank_q;
        addr_d = ROW_W'(col_q);
`ifdef SDRAM_SEQ_AUTO_PRECHARGE_EN
        addr_d[A10] = 1'b1;
`endif
        if (wr_q) begin
          oe_d  = 1'b1;
          dqo_d = wdata_q;
        end
      end
      S_PRECHARGE: begin
        cmd_d = CMD_PRE;
        ba_d  = bank_q;
      end
      S_REFRESH: begin
        cmd_d = CMD_AREF;
        ack_d = 1'b1;
      end
      default: begin
        cmd_d = CMD_NOP;
      end
    endcase
  end

  // State, request fields and all pin/host outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wdata_q <= '0;
      cmd_q   <= CMD_NOP;
      ba_q    <= '0;
      addr_q  <= '0;
      dqo_q   <= '0;
      oe_q    <= 1'b0;
      rdv_q   <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wdata_q <= wdata_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      dqo_q   <= dqo_d;
      oe_q    <= oe_d;
      rdv_q   <= rdv_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd_q;

  assign sd_ba     = ba_q;
  assign sd_addr   = addr_q;
  assign sd_dq_out = dqo_q;
  assign sd_dq_oe  = oe_q;
  assign rd_valid  = rdv_q;
  assign rd_data   = rdata_q;
  assign ref_ack   = ack_q;
  assign rcd_start = start_q;
  assign rcd_err   = err_q;
  assign req_ready = ready_q;

endmodule

// File: tb/tb_sdram_access_sequencer.sv
// Scoreboard bench for sdram_access_sequencer.
// Build option: SDRAM_SEQ_AUTO_PRECHARGE_EN changes expectations.
module tb_sdram_access_sequencer;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] ACT  = 4'b0011;
  localparam logic [3:0] RD   = 4'b0101;
  localparam logic [3:0] WR   = 4'b0100;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] RDV  = 4'b1111;
  localparam logic [7:0] ANY  = 8'hFF;

`ifdef SDRAM_SEQ_AUTO_PRECHARGE_EN
  localparam logic [12:0] APB = 13'h0400;
`else
  localparam logic [12:0] APB = 13'h0000;
`endif

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        oe;
    logic [15:0] dq;
    logic        ack;
    logic [7:0]  gap;
  } ev_t;

  logic        clk = 0;
  logic        reset;
  logic        req_valid = 0;
  logic        req_ready;
  logic        req_write = 0;
  logic [1:0]  req_bank = 0;
  logic [12:0] req_row = 0;
  logic [8:0]  req_col = 0;
  logic [15:0] req_wdata = 0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        ref_req = 0;
  logic        ref_ack;
  logic        rcd_start;
  logic        rcd_int = 0;
  logic        rcd_err;
  logic        sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n;
  logic [1:0]  sd_ba;
  logic [12:0] sd_addr;
  logic [15:0] sd_dq_out;
  logic        sd_dq_oe;
  logic [15:0] sd_dq_in = 0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_cyc = 0;
  int n_ev = 0;
  ev_t exp_q[$];

  sdram_access_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_bank  (req_bank),
    .req_row   (req_row),
    .req_col   (req_col),
    .req_wdata (req_wdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .ref_req   (ref_req),
    .ref_ack   (ref_ack),
    .rcd_start (rcd_start),
    .rcd_int   (rcd_int),
    .rcd_err   (rcd_err),
    .sd_cs_n   (sd_cs_n),
    .sd_ras_n  (sd_ras_n),
    .sd_cas_n  (sd_cas_n),
    .sd_we_n   (sd_we_n),
    .sd_ba     (sd_ba),
    .sd_addr   (sd_addr),
    .sd_dq_out (sd_dq_out),
    .sd_dq_oe  (sd_dq_oe),
    .sd_dq_in  (sd_dq_in)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  function automatic ev_t mk(
    input logic [3:0] c, input logic [1:0] b,
    input logic [12:0] a, input logic o,
    input logic [15:0] d, input logic k,
    input logic [7:0] g);
    ev_t e;
    e.cmd = c; e.ba = b; e.addr = a; e.oe = o;
    e.dq = d; e.ack = k; e.gap = g;
    return e;
  endfunction

  task automatic push(input ev_t e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic check_ev(input ev_t o);
    ev_t e;
    int g;
    total++;
    g = cyc - last_cyc;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL ev%0d unexpected: cmd=%b ba=%0d addr=%h dq=%h",
               n_ev, o.cmd, o.ba, o.addr, o.dq);
    end else begin
      e = exp_q.pop_front();
      o.gap = (e.gap == ANY) ? ANY : g[7:0];
      if (o !== e) begin
        bad++;
        $display({"FAIL ev%0d: got cmd=%b ba=%0d addr=%h oe=%b",
                  " dq=%h ack=%b gap=%0d want cmd=%b ba=%0d",
                  " addr=%h oe=%b dq=%h ack=%b gap=%0d"},
                 n_ev, o.cmd, o.ba, o.addr, o.oe, o.dq, o.ack,
                 o.gap, e.cmd, e.ba, e.addr, e.oe, e.dq, e.ack,
                 e.gap);
      end
    end
    last_cyc = cyc;
    n_ev++;
  endtask

  always @(negedge clk) begin
    logic [3:0] c;
    cyc++;
    if (reset) begin
      c = {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n};
      if (c != NOP)
        check_ev(mk(c, sd_ba, sd_addr, sd_dq_oe, sd_dq_out,
                    ref_ack, 8'd0));
      if (rd_valid)
        check_ev(mk(RDV, 2'd0, 13'd0, 1'b0, rd_data, 1'b0, 8'd0));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!rcd_start && n < 20) begin
      tick();
      n++;
    end
    chk("rcd_start_wait", 32'(rcd_start), 32'd1);
  endtask

  task automatic issue(input logic w, input logic [1:0] b,
                       input logic [12:0] r, input logic [8:0] c,
                       input logic [15:0] d);
    wait_ready();
    req_valid = 1; req_write = w; req_bank = b;
    req_row = r; req_col = c; req_wdata = d;
    tick();
    req_valid = 0;
  endtask

  task automatic rcd_pulse(input int d);
    wait_start();
    tick(d);
    rcd_int = 1;
    tick();
    rcd_int = 0;
  endtask

  task automatic rd_phase(input logic [15:0] v);
    tick();
    sd_dq_in = v;
    tick();
    sd_dq_in = 16'h0;
  endtask

  task automatic push_post_read(input logic [1:0] b,
                                input logic [15:0] v);
`ifdef SDRAM_SEQ_AUTO_PRECHARGE_EN
    push(mk(RDV, 2'd0, 13'd0, 1'b0, v, 1'b0, 8'd2));
`else
    push(mk(PRE, b, 13'd0, 1'b0, 16'h0, 1'b0, 8'd2));
    push(mk(RDV, 2'd0, 13'd0, 1'b0, v, 1'b0, 8'd0));
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd"},
        32'({sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n}), 32'(NOP));
    chk({tag, "_ba"}, 32'(sd_ba), 32'd0);
    chk({tag, "_addr"}, 32'(sd_addr), 32'd0);
    chk({tag, "_dqout"}, 32'(sd_dq_out), 32'd0);
    chk({tag, "_rddata"}, 32'(rd_data), 32'd0);
    chk({tag, "_flags"},
        32'({sd_dq_oe, rd_valid, ref_ack, rcd_start, rcd_err}),
        32'd0);
  endtask

  initial begin
    reset = 1;
    #1 reset = 0;
    #2 check_reset_vals("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1;
    tick();
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Read: bank 1, row 0x0123, col 0x045, rcd_int 3 clocks in.
    push(mk(ACT, 2'd1, 13'h0123, 1'b0, 16'h0, 1'b0, ANY));
    push(mk(RD, 2'd1, 13'h0045 | APB, 1'b0, 16'h0, 1'b0, 8'd5));
    push_post_read(2'd1, 16'hBEEF);
    issue(1'b0, 2'd1, 13'h0123, 9'h045, 16'h0);
    rcd_pulse(3);
    rd_phase(16'hBEEF);
    tick();
    chk("rd_ready_low", 32'(req_ready), 32'd0);
    tick();
    chk("rd_ready_back", 32'(req_ready), 32'd1);

    // Write 0xA5A5 to bank 2.
    push(mk(ACT, 2'd2, 13'h1ABC, 1'b0, 16'h0, 1'b0, ANY));
    push(mk(WR, 2'd2, 13'h01F0 | APB, 1'b1, 16'hA5A5, 1'b0, 8'd2));
`ifndef SDRAM_SEQ_AUTO_PRECHARGE_EN
    push(mk(PRE, 2'd2, 13'd0, 1'b0, 16'h0, 1'b0, 8'd1));
`endif
    issue(1'b1, 2'd2, 13'h1ABC, 9'h1F0, 16'hA5A5);
    rcd_pulse(0);
    tick();
    chk("wr_oe_drop", 32'(sd_dq_oe), 32'd0);

    // Refresh and request together: refresh wins.
    wait_ready();
    push(mk(AREF, 2'd0, 13'd0, 1'b0, 16'h0, 1'b1, ANY));
    push(mk(ACT, 2'd3, 13'h0F0F, 1'b0, 16'h0, 1'b0, 8'd8));
    push(mk(RD, 2'd3, 13'h01FF | APB, 1'b0, 16'h0, 1'b0, 8'd2));
    push_post_read(2'd3, 16'h1234);
    ref_req = 1; req_valid = 1; req_write = 0;
    req_bank = 2'd3; req_row = 13'h0F0F; req_col = 9'h1FF;
    tick();
    chk("ref_ack", 32'(ref_ack), 32'd1);
    ref_req = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rfc_ready_low", 32'(req_ready), 32'd0);
    end
    tick();
    chk("rfc_ready_back", 32'(req_ready), 32'd1);
    tick();
    req_valid = 0;
    rcd_pulse(0);
    rd_phase(16'h1234);

    // tRCD timeout: rcd_int never arrives.
    push(mk(ACT, 2'd0, 13'h1FFF, 1'b0, 16'h0, 1'b0, ANY));
    push(mk(RD, 2'd0, 13'h0000 | APB, 1'b0, 16'h0, 1'b0, 8'd9));
    push_post_read(2'd0, 16'h0F0F);
    issue(1'b0, 2'd0, 13'h1FFF, 9'h000, 16'h0);
    tick();
    chk("to_start_w1", 32'({rcd_start, rcd_err}), 32'b10);
    tick(7);
    chk("to_start_w8", 32'({rcd_start, rcd_err}), 32'b10);
    tick();
    chk("to_err_set", 32'({rcd_start, rcd_err}), 32'b01);
    rd_phase(16'h0F0F);
    wait_ready();
    chk("to_err_sticky", 32'(rcd_err), 32'd1);

    // Reset during WAIT_CL drops the read.
    push(mk(ACT, 2'd1, 13'h0002, 1'b0, 16'h0, 1'b0, ANY));
    push(mk(RD, 2'd1, 13'h0003 | APB, 1'b0, 16'h0, 1'b0, 8'd3));
    issue(1'b0, 2'd1, 13'h0002, 9'h003, 16'h0);
    rcd_pulse(1);
    tick();
    sd_dq_in = 16'hDEAD;
    #2 reset = 0;
    #1 check_reset_vals("midrst");
    tick();
    reset = 1;
    sd_dq_in = 16'h0;
    tick();
    chk("midrst_ready", 32'(req_ready), 32'd1);

    tick(6);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_access_sequencer.md
Name: sdram_access_sequencer

Overview:
- Single-access SDRAM command sequencer. Issues ACTIVE, then READ or WRITE, then PRECHARGE for one host request at a time, and also services refresh requests.
- Initiator side of the tRCD timer handshake: drives rcd_start and consumes rcd_int from the external tRCD timer.
- tRP, tRFC and CAS latency are counted internally.
- Sits between the host request port and the SDRAM pins, beside the tRCD and refresh timers.

Parameters:
- ROW_W, 13, row address width
- COL_W, 9, column address width (≤ ROW_W, excluding A10)
- BANK_W, 2, bank address width
- DATA_W, 16, DQ width
- CAS_LAT, 2, read CAS latency in clocks (2 or 3)
- T_RP, 2, PRECHARGE-to-next-command clocks
- T_RFC, 7, AUTO REFRESH-to-next-command clocks
- RCD_TIMEOUT, 8, max WAIT_RCD clocks before error

Ports:
- clk, in, 1, clock
- reset, in, 1, asynchronous active-low reset
- req_valid, in, 1, host request valid
- req_ready, out, 1, sequencer accepts request
- req_write, in, 1, 1=write, 0=read
- req_bank, in, BANK_W, bank
- req_row, in, ROW_W, row
- req_col, in, COL_W, column
- req_wdata, in, DATA_W, write data
- rd_valid, out, 1, one-cycle read data strobe
- rd_data, out, DATA_W, read data
- ref_req, in, 1, refresh request level from refresh timer
- ref_ack, out, 1, one-cycle pulse when AUTO REFRESH issued
- rcd_start, out, 1, tRCD timer run enable
- rcd_int, in, 1, tRCD expiry pulse
- rcd_err, out, 1, sticky: tRCD timeout occurred
- sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, out, 1 each, command pins
- sd_ba, out, BANK_W, bank pins
- sd_addr, out, ROW_W, address pins
- sd_dq_out, out, DATA_W, write data
- sd_dq_oe, out, 1, DQ output enable
- sd_dq_in, in, DATA_W, DQ input

Behaviour:
- Reset (reset=0, async):
  - State IDLE; command NOP (cs_n=0, ras_n=cas_n=we_n=1).
  - sd_ba, sd_addr, sd_dq_out, rd_data = 0.
  - sd_dq_oe, rd_valid, ref_ack, rcd_start, rcd_err = 0.
  - All counters = 0.
- All outputs are registered. Exactly one command is issued per clock; NOP unless stated otherwise.
- req_ready = 1 only in IDLE with ref_req = 0. A request is accepted on req_valid & req_ready; bank, row, col, write and wdata are latched.
- Refresh has priority: if ref_req = 1 in IDLE, go to REFRESH even when req_valid = 1. ref_req is ignored outside IDLE; the refresh timer holds it until ref_ack.
- States and transitions:
  - IDLE -> ACTIVATE on accept; -> REFRESH on ref_req.
  - ACTIVATE: issue ACTIVE with sd_ba = bank, sd_addr = row. Next WAIT_RCD.
  - WAIT_RCD: rcd_start = 1 throughout the state. On the cycle rcd_int = 1 is sampled, rcd_start drops and the state goes to RW. If RCD_TIMEOUT clocks pass without rcd_int, set rcd_err and go to RW anyway. rcd_int outside WAIT_RCD is ignored.
  - RW: issue READ or WRITE with sd_ba = bank, sd_addr = zero-extended col, A10 = 0.
    - Write: sd_dq_oe = 1 and sd_dq_out = wdata for this cycle only. Next PRECHARGE.
    - Read: next WAIT_CL.
  - WAIT_CL: count CAS_LAT clocks from READ. On the CAS_LAT-th rising edge after READ, capture sd_dq_in into rd_data and pulse rd_valid one cycle. Next PRECHARGE.
  - PRECHARGE: issue PRECHARGE with sd_ba = bank, A10 = 0. Next WAIT_RP.
  - WAIT_RP: T_RP-1 NOP clocks, then IDLE.
  - REFRESH: issue AUTO REFRESH; ref_ack = 1 for this cycle. Next WAIT_RFC.
  - WAIT_RFC: T_RFC-1 NOP clocks, then IDLE.
- Latency, read: accept -> ACTIVE +1, READ at +2+tRCD, rd_valid at READ+CAS_LAT.
- Latency, write: PRECHARGE follows WRITE on the next clock. No tWR modelling beyond that.
- Reset mid-operation: immediate return to IDLE/NOP. An in-flight access is dropped with no rd_valid. rcd_err is cleared.
- Counter widths: $clog2(max(T_RFC, RCD_TIMEOUT) + 1).

Optional Feature:
- Macro: SDRAM_SEQ_AUTO_PRECHARGE_EN
- Defined: RW sets sd_addr[10] = 1 (READA/WRITEA). PRECHARGE state is skipped.
  - Write: WRITE -> WAIT_RP (T_RP clocks) -> IDLE.
  - Read: WAIT_CL -> WAIT_RP -> IDLE.
- Undefined: explicit PRECHARGE as above; A10 = 0 in RW.

Decomposition:
- Package sdram_pkg holds:
  - command encodings {cs_n, ras_n, cas_n, we_n}: NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, PRECHARGE 0010, AUTO_REFRESH 0001
  - the state enum
  - default timing constants
- One natural sub-module, sdram_delay_counter: load value, count down, done flag. Used for tRP, tRFC, CAS latency and tRCD timeout.

Test Plan:
- Read, bank 1, row 0x0123, col 0x045; rcd_int 3 clocks after rcd_start rises; sd_dq_in = 0xBEEF at READ+2 -> ACTIVE(ba=1, addr=0x0123), READ(addr=0x045), rd_valid = 1 with rd_data = 0xBEEF exactly 2 clocks after READ, PRECHARGE next, req_ready back after T_RP.
- Write, 0xA5A5 to bank 2 -> WRITE cycle has sd_dq_oe = 1, sd_dq_out = 0xA5A5, A10 = 0; sd_dq_oe = 0 on the next cycle, which is PRECHARGE.
- ref_req and req_valid high together in IDLE -> AUTO REFRESH first, ref_ack pulse, 6 NOPs, then ACTIVE for the request.
- rcd_int held 0 -> rcd_err = 1 after 8 WAIT_RCD clocks, READ still issued; rcd_err stays 1 until reset.
- reset low during WAIT_CL -> outputs at reset values asynchronously, no rd_valid; after release req_ready = 1.
- With SDRAM_SEQ_AUTO_PRECHARGE_EN -> READ has sd_addr[10] = 1 and no PRECHARGE command appears.
